// File: rtl/ctrl_signal_types.sv
// ---------------------------------------------------------------------------
// ctrl_signal_types
// Shared control-signal types for the page-access-counter datapath.
//
// Contents:
//   mem_request_t    - packed memory request: address[26:0], read, write
//   MEM_ADDR_W       - request address width
//   MEM_REQUEST_IDLE - all-zero request (no read, no write, address 0)
//   mem_req_valid()  - a request is valid when it reads or writes
// ---------------------------------------------------------------------------
package ctrl_signal_types;

    localparam int MEM_ADDR_W = 27;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
    } mem_request_t;

    localparam mem_request_t MEM_REQUEST_IDLE = '0;

    function automatic logic mem_req_valid(input mem_request_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
// Purely combinational rotating-priority search. Starting at ptr, scans
// ptr, ptr+1, ... NUM_INPUT_PORT-1, 0, ... ptr-1 and picks the first set
// request bit.
//
// Parameters:
//   NUM_INPUT_PORT - number of request inputs (>= 2)
// Ports:
//   req        in  [NUM_INPUT_PORT-1:0] per-port request valid
//   ptr        in  [PTR_W-1:0]          highest-priority port
//   win_onehot out [NUM_INPUT_PORT-1:0] one-hot winner (zero if no request)
//   win_idx    out [PTR_W-1:0]          winner index (zero if no request)
//   any_req    out                      at least one request bit set
// ---------------------------------------------------------------------------
module rr_priority_select #(
    parameter int NUM_INPUT_PORT = 2,
    localparam int PTR_W = $clog2(NUM_INPUT_PORT)
) (
    input  logic [NUM_INPUT_PORT-1:0] req,
    input  logic [PTR_W-1:0]          ptr,
    output logic [NUM_INPUT_PORT-1:0] win_onehot,
    output logic [PTR_W-1:0]          win_idx,
    output logic                      any_req
);

    int   idx;
    logic found;

    // Walk the ports in priority order; the found flag freezes the first hit
    // so later candidates in the scan cannot override it.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_INPUT_PORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_INPUT_PORT)
                idx = idx - NUM_INPUT_PORT;
            if (!found && req[idx]) begin
                found           = 1'b1;
                win_onehot[idx] = 1'b1;
                win_idx         = PTR_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
// Merges NUM_INPUT_PORT memory-request streams onto one downstream (EMIF)
// port. A rotating pointer gives one port top priority; after each transfer
// the pointer moves just past the winner so no requester starves.
//
// Grant and out_request are combinational from req, in_request,
// out_port_ready and ptr. out_request shows the current candidate whether or
// not the downstream port is ready (its read|write acts as valid); grant
// fires only when a transfer actually happens.
//
// Parameters:
//   NUM_INPUT_PORT - number of request inputs (>= 2), default 2
// Ports:
//   clk            in  clock, rising edge
//   reset_n        in  asynchronous active-low reset
//   req            in  [NUM_INPUT_PORT-1:0] per-port request valid
//   in_request     in  mem_request_t [NUM_INPUT_PORT] per-port requests
//   out_port_ready in  downstream can accept this cycle
//   out_request    out mem_request_t selected request (all-zero when idle)
//   grant          out [NUM_INPUT_PORT-1:0] one-hot transfer acknowledge
//
// Build option:
//   RR_ARB_ASSERT_EN - compiles in simulation-only protocol assertions; the
//                      synthesized logic is the same with or without it.
// ---------------------------------------------------------------------------
module round_robin_arbiter
    import ctrl_signal_types::*;
#(
    parameter int NUM_INPUT_PORT = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_INPUT_PORT-1:0] req,
    input  mem_request_t              in_request [NUM_INPUT_PORT],
    input  logic                      out_port_ready,
    output mem_request_t              out_request,
    output logic [NUM_INPUT_PORT-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_INPUT_PORT);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_INPUT_PORT - 1);

    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_next;
    logic [NUM_INPUT_PORT-1:0] win_onehot;
    logic [PTR_W-1:0]          win_idx;
    logic                      any_req;
    logic                      xfer;

    rr_priority_select #(
        .NUM_INPUT_PORT (NUM_INPUT_PORT)
    ) u_select (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_req    (any_req)
    );

    // reset_n gates the combinational outputs too, so nothing leaks
    // downstream while the block is held in reset.
    assign xfer = reset_n & any_req & out_port_ready;

    always_comb begin
        out_request = MEM_REQUEST_IDLE;
        if (reset_n && any_req)
            out_request = in_request[win_idx];
    end

    for (genvar i = 0; i < NUM_INPUT_PORT; i++) begin : g_grant
        assign grant[i] = xfer & win_onehot[i];
    end

    // Explicit wrap keeps the pointer legal for non-power-of-two port counts.
    assign ptr_next = (win_idx == LAST_PORT) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (xfer)
            ptr <= ptr_next;
    end

`ifdef RR_ARB_ASSERT_EN
    a_grant_onehot0: assert property (
        @(posedge clk) disable iff (!reset_n) $onehot0(grant));

    a_grant_needs_req: assert property (
        @(posedge clk) disable iff (!reset_n) (grant & ~req) == '0);

    a_no_grant_when_stalled: assert property (
        @(posedge clk) disable iff (!reset_n) !out_port_ready |-> grant == '0);

    a_no_read_write_merge: assert property (
        @(posedge clk) disable iff (!reset_n)
        (any_req && (in_request[win_idx].read ^ in_request[win_idx].write))
            |-> !(out_request.read && out_request.write));
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;
    import ctrl_signal_types::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Two-port instance
    logic [1:0]   req2;
    mem_request_t in2 [2];
    logic         rdy2;
    mem_request_t out2;
    logic [1:0]   gnt2;

    // Four-port instance
    logic [3:0]   req4;
    mem_request_t in4 [4];
    logic         rdy4;
    mem_request_t out4;
    logic [3:0]   gnt4;

    int total  = 0;
    int passed = 0;

    round_robin_arbiter #(.NUM_INPUT_PORT(2)) dut2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req2),
        .in_request     (in2),
        .out_port_ready (rdy2),
        .out_request    (out2),
        .grant          (gnt2)
    );

    round_robin_arbiter #(.NUM_INPUT_PORT(4)) dut4 (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req4),
        .in_request     (in4),
        .out_port_ready (rdy4),
        .out_request    (out4),
        .grant          (gnt4)
    );

    function automatic mem_request_t mk(input logic [26:0] a, input logic r, input logic w);
        mem_request_t m;
        m.address = a;
        m.read    = r;
        m.write   = w;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change just after the falling edge and
    // outputs are sampled 1 time unit later, well away from the rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mem_request_t r8, wa, r86, wa4, idle;
        r8   = mk(27'h8, 1'b1, 1'b0);
        wa   = mk(27'hA, 1'b0, 1'b1);
        r86  = mk(27'h86, 1'b1, 1'b0);
        wa4  = mk(27'hA4, 1'b0, 1'b1);
        idle = '0;

        // ---- reset: outputs forced idle even with requests pending
        reset_n = 1'b0;
        req2 = 2'b11; in2[0] = r8; in2[1] = wa; rdy2 = 1'b1;
        req4 = 4'b1111;
        for (int i = 0; i < 4; i++) in4[i] = mk(27'(32'h100 + i), 1'b1, 1'b0);
        rdy4 = 1'b1;
        #1;
        chk("rst_grant2", 32'(gnt2), 32'h0);
        chk("rst_out2",   32'(out2), 32'(idle));
        chk("rst_grant4", 32'(gnt4), 32'h0);
        chk("rst_out4",   32'(out4), 32'(idle));

        req2 = 2'b00; req4 = 4'b0000;
        tick();
        reset_n = 1'b1;
        #1;
        chk("idle_grant", 32'(gnt2), 32'h0);
        chk("idle_out",   32'(out2), 32'(idle));

        // ---- port 0 alone: granted every cycle
        req2 = 2'b01; in2[0] = r8; rdy2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("p0_grant", 32'(gnt2), 32'h1);
            chk("p0_out",   32'(out2), 32'(r8));
            tick();
        end

        // ---- port 1 alone (ptr now 1, ends at 0)
        req2 = 2'b10; in2[1] = wa;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("p1_grant", 32'(gnt2), 32'h2);
            chk("p1_out",   32'(out2), 32'(wa));
            tick();
        end

        // ---- both requesting from ptr=0: strict alternation
        req2 = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("alt_grant", 32'(gnt2), (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_out",   32'(out2), (c % 2 == 0) ? 32'(r8) : 32'(wa));
            tick();
        end

        // ---- stall / resume / stall with ptr=0
        in2[0] = r86; in2[1] = wa4; rdy2 = 1'b0;
        #1;
        chk("stall_grant", 32'(gnt2), 32'h0);
        chk("stall_out",   32'(out2), 32'(r86));
        tick();
        rdy2 = 1'b1;
        #1;
        chk("go_grant0", 32'(gnt2), 32'h1);
        chk("go_out0",   32'(out2), 32'(r86));
        tick();
        #1;
        chk("go_grant1", 32'(gnt2), 32'h2);
        chk("go_out1",   32'(out2), 32'(wa4));
        tick();
        rdy2 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("hold_grant", 32'(gnt2), 32'h0);
            chk("hold_out",   32'(out2), 32'(r86));
            tick();
        end
        // ptr must still be 0 after the stall
        rdy2 = 1'b1;
        #1;
        chk("hold_ptr", 32'(gnt2), 32'h1);
        tick();

        // ---- four ports: move ptr to 2, then ports 1 and 3 wrap around
        req4 = 4'b0010;
        #1;
        chk("n4_setup", 32'(gnt4), 32'h2);
        tick();
        req4 = 4'b1010;
        #1;
        chk("n4_g3a",   32'(gnt4), 32'h8);
        chk("n4_out3",  32'(out4), 32'(in4[3]));
        tick();
        #1;
        chk("n4_g1",    32'(gnt4), 32'h2);
        chk("n4_out1",  32'(out4), 32'(in4[1]));
        tick();
        #1;
        chk("n4_g3b",   32'(gnt4), 32'h8);
        tick();
        req4 = 4'b0000;
        #1;
        chk("n4_idle",  32'(gnt4), 32'h0);

        // ---- reset mid-rotation: ptr=1 before reset, port 0 first after
        // (dut2 ptr is 1 here after the hold_ptr grant of port 0)
        req2 = 2'b11; in2[0] = r8; in2[1] = wa;
        #1;
        chk("pre_rst_grant", 32'(gnt2), 32'h2);
        tick();
        #1;
        chk("pre_rst_grant2", 32'(gnt2), 32'h1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(gnt2), 32'h0);
        chk("mid_rst_out",   32'(out2), 32'(idle));
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(gnt2), 32'h1);
        chk("post_rst_out",   32'(out2), 32'(r8));
        tick();
        #1;
        chk("post_rst_next",  32'(gnt2), 32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

N-input round-robin arbiter that merges several memory-request streams onto a single downstream memory port (EMIF side) inside the page-access-counter datapath. Each cycle it selects one requesting input, starting the search from a rotating priority pointer, and presents that input's request on the output port. A grant is issued only when the downstream port is ready. Priority then rotates past the granted port so that no requester starves.

## Interface
Parameters:
- NUM_INPUT_PORT, default 2: number of request inputs; legal values ≥ 2.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- reset_n  in  1: reset, asynchronous and active-low.
- req  in  NUM_INPUT_PORT: per-port request valid; bit i = in_request[i].read | in_request[i].write, generated by the requester side.
- in_request  in  mem_request_t [NUM_INPUT_PORT]: unpacked array of per-port requests.
- out_port_ready  in  1: downstream port can accept a request this cycle.
- out_request  out  mem_request_t: selected request presented downstream.
- grant  out  NUM_INPUT_PORT: one-hot acknowledge to the winning port; all-zero when no transfer occurs.

## Operation
- State consists only of the priority pointer ptr, which is $clog2(NUM_INPUT_PORT) bits wide. ptr is the port that has highest priority.
- Winner selection is combinational: the first i with req[i]=1, searching ptr, ptr+1, … NUM_INPUT_PORT-1, 0, … ptr-1 (modulo wrap).
- out_request = in_request[winner] whenever any req bit is set, independent of out_port_ready. This acts as a valid/hold presentation: out_request.read|write is the valid signal.
- When no req bit is set, out_request = all-zero (read=0, write=0, address=0).
- grant = onehot(winner) when (|req) && out_port_ready; otherwise grant = 0.
- Transfer occurs when grant is nonzero. On a transfer, ptr ← (winner+1) mod NUM_INPUT_PORT, with wrap from NUM_INPUT_PORT-1 to 0.
- No transfer (no req, or out_port_ready=0): ptr holds. While stalled, out_request keeps showing the same candidate as long as the inputs are unchanged.
- Lone requester: that port is granted every ready cycle.
- All ports requesting continuously: grants rotate 0,1,…,N-1,0,….
- Requesters treat grant as consumption of their current request and present their next request (or deassert) in the following cycle.

## Timing
- Grant and out_request have zero-cycle latency, i.e. they are combinational from req, in_request, out_port_ready and ptr.
- ptr update takes effect on the rising edge after the transfer cycle.
- Reset: ptr = 0 asynchronously.
- While reset_n = 0: grant = 0 and out_request = all-zero, regardless of the inputs.
- Reset asserted mid-stream: the next arbitration after release starts from port 0.
- Simultaneous requests at the pointer boundary are resolved purely by ptr order; there is no age tracking.

## Configuration
- RR_ARB_ASSERT_EN defined: simulation-only assertions are compiled in:
  - $onehot0(grant);
  - (grant & ~req) == 0;
  - grant == 0 when out_port_ready == 0;
  - out_request.read and out_request.write are never both 1 when they originate from a single port that asserts only one of them.
- RR_ARB_ASSERT_EN undefined: no assertions; synthesized logic is identical in both cases.

## Structure
- mem_request_t belongs in the shared package ctrl_signal_types, as a packed struct: address [26:0], read, write.
- No sub-module is required. The winner search may be factored into a sub-module rr_priority_select, which is purely combinational: inputs req and ptr, outputs one-hot winner and winner index.

## Test plan
- Port 0 only: read, address 0x8, out_port_ready=1 for 3 cycles. Expected: each cycle out_request = {0x8, read}, grant = 01.
- Port 1 only: write, address 0xA, for 3 cycles. Expected: out_request = {0xA, write}, grant = 10 every cycle.
- Both ports requesting (port 0 read 0x8, port 1 write 0xA), ready=1, starting at ptr=0. Expected: grant alternates 01,10,01,10,01,10 and out_request alternates 0x8, 0xA correspondingly.
- Both requesting (0x86 read, 0xA4 write), ready=0. Expected: grant = 00, out_request = port 0's request. Then ready=1: grant 01, then 10. Then ready=0: grant 00, out_request = port 0's request held for 2 cycles, ptr unchanged.
- NUM_INPUT_PORT=4, ports 1 and 3 requesting, ptr=2. Expected: grant 1000, then 0010, then 1000 (wrap-around).
- Reset asserted mid-rotation with ptr=1 and both ports requesting. Expected: after release the first grant is 01.
